// File: rtl/rollback_sequencer.sv
// Rollback sequencer: tracks one IDLE/PENDING/FLUSH machine per hardware thread, arbitrates three
// prioritised rollback sources per thread and issues one registered rollback per cycle round-robin.
module rollback_sequencer #(
    parameter  int THREAD_NUMB  = 8,
    parameter  int FLUSH_CYCLES = 3,
    localparam int IDW          = $clog2(THREAD_NUMB),
    localparam int CW           = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,

    // Requests are valid-only: a source asserts valid for one cycle with its payload and there
    // is no ready/backpressure; a request the sequencer cannot use is dropped, never stalled.
    input  logic                     wb_rollback_valid,
    input  logic [IDW-1:0]           wb_rollback_thread_id,
    input  logic [31:0]              wb_rollback_pc,
    input  logic [63:0]              wb_scoreboard,

    input  logic                     bc_rollback_enable,
    input  logic [IDW-1:0]           bc_rollback_thread_id,
    input  logic [31:0]              bc_rollback_pc,
    input  logic [63:0]              bc_scoreboard,

    input  logic                     dec_rollback_valid,
    input  logic [IDW-1:0]           dec_rollback_thread_id,
    input  logic [31:0]              dec_rollback_pc,
    input  logic [63:0]              dec_scoreboard,

    output logic                     rb_valid,
    output logic [IDW-1:0]           rb_thread_id,
    output logic [31:0]              rb_pc,
    output logic [63:0]              rb_scoreboard,
    output logic [THREAD_NUMB-1:0]   rb_flush_mask,

    output logic [2*THREAD_NUMB-1:0] dbg_thread_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } thread_state_t;

    thread_state_t  state_q [THREAD_NUMB];
    thread_state_t  state_d [THREAD_NUMB];
    logic [1:0]     src_q   [THREAD_NUMB];
    logic [1:0]     src_d   [THREAD_NUMB];
    logic [31:0]    pc_q    [THREAD_NUMB];
    logic [31:0]    pc_d    [THREAD_NUMB];
    logic [63:0]    sb_q    [THREAD_NUMB];
    logic [63:0]    sb_d    [THREAD_NUMB];
    logic [CW-1:0]  cnt_q   [THREAD_NUMB];
    logic [CW-1:0]  cnt_d   [THREAD_NUMB];

    logic           req_hit [THREAD_NUMB];
    logic [1:0]     req_src [THREAD_NUMB];
    logic [31:0]    req_pc  [THREAD_NUMB];
    logic [63:0]    req_sb  [THREAD_NUMB];

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] cand_idx;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;

    // Per-thread request decode; later assignments override earlier ones so the lowest source wins.
    always_comb begin
        for (int t = 0; t < THREAD_NUMB; t++) begin
            req_hit[t] = 1'b0;
            req_src[t] = 2'd3;
            req_pc[t]  = '0;
            req_sb[t]  = '0;
            if (dec_rollback_valid && dec_rollback_thread_id == IDW'(t)) begin
                req_hit[t] = 1'b1;
                req_src[t] = 2'd2;
                req_pc[t]  = dec_rollback_pc;
                req_sb[t]  = dec_scoreboard;
            end
            if (bc_rollback_enable && bc_rollback_thread_id == IDW'(t)) begin
                req_hit[t] = 1'b1;
                req_src[t] = 2'd1;
                req_pc[t]  = bc_rollback_pc;
                req_sb[t]  = bc_scoreboard;
            end
            if (wb_rollback_valid && wb_rollback_thread_id == IDW'(t)) begin
                req_hit[t] = 1'b1;
                req_src[t] = 2'd0;
                req_pc[t]  = wb_rollback_pc;
                req_sb[t]  = wb_scoreboard;
            end
        end
    end

    // Round-robin search starts at the pointer; index arithmetic wraps because THREAD_NUMB is 2^k.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        cand_idx  = '0;
        for (int i = 0; i < THREAD_NUMB; i++) begin
            cand_idx = rr_ptr_q + IDW'(i);
            if (!gnt_found && state_q[cand_idx] == ST_PENDING) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        rr_ptr_d = gnt_found ? gnt_idx + IDW'(1) : rr_ptr_q;
    end

    always_comb begin
        for (int t = 0; t < THREAD_NUMB; t++) begin
            state_d[t] = state_q[t];
            src_d[t]   = src_q[t];
            pc_d[t]    = pc_q[t];
            sb_d[t]    = sb_q[t];
            cnt_d[t]   = cnt_q[t];
            case (state_q[t])
                ST_IDLE: begin
                    if (req_hit[t]) begin
                        state_d[t] = ST_PENDING;
                        src_d[t]   = req_src[t];
                        pc_d[t]    = req_pc[t];
                        sb_d[t]    = req_sb[t];
                    end
                end
                ST_PENDING: begin
                    // An older source replaces the entry and keeps the thread pending, even in its
                    // grant cycle; the rollback registered this cycle still uses the old entry.
                    if (req_hit[t] && req_src[t] < src_q[t]) begin
                        src_d[t] = req_src[t];
                        pc_d[t]  = req_pc[t];
                        sb_d[t]  = req_sb[t];
                    end else if (gnt_found && gnt_idx == IDW'(t)) begin
                        state_d[t] = ST_FLUSH;
                        cnt_d[t]   = CW'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q[t] <= CW'(1)) begin
                        state_d[t] = ST_IDLE;
                        cnt_d[t]   = '0;
                    end else begin
                        cnt_d[t] = cnt_q[t] - CW'(1);
                    end
                end
                default: begin
                    state_d[t] = ST_IDLE;
                    cnt_d[t]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < THREAD_NUMB; t++) begin
                state_q[t] <= ST_IDLE;
                src_q[t]   <= '0;
                pc_q[t]    <= '0;
                sb_q[t]    <= '0;
                cnt_q[t]   <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int t = 0; t < THREAD_NUMB; t++) begin
                state_q[t] <= state_d[t];
                src_q[t]   <= src_d[t];
                pc_q[t]    <= pc_d[t];
                sb_q[t]    <= sb_d[t];
                cnt_q[t]   <= cnt_d[t];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Payload outputs hold their last value when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_valid      <= 1'b0;
            rb_thread_id  <= '0;
            rb_pc         <= '0;
            rb_scoreboard <= '0;
        end else begin
            rb_valid <= gnt_found;
            if (gnt_found) begin
                rb_thread_id  <= gnt_idx;
                rb_pc         <= pc_q[gnt_idx];
                rb_scoreboard <= sb_q[gnt_idx];
            end
        end
    end

    always_comb begin
        rb_flush_mask    = '0;
        dbg_thread_state = '0;
        for (int t = 0; t < THREAD_NUMB; t++) begin
            rb_flush_mask[t]          = (state_q[t] == ST_FLUSH);
            dbg_thread_state[2*t +: 2] = state_q[t];
        end
    end

endmodule

// File: tb/tb_rollback_sequencer.sv
// Bench for rollback_sequencer: directed scenarios plus random traffic, all checked against a
// per-thread behavioural model and an expected-rollback queue.
module tb_rollback_sequencer;

    localparam int N   = 8;
    localparam int FC  = 3;
    localparam int IDW = 3;
    localparam int W   = IDW + 32 + 64;

    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_FLUSH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             rq_v  [3];
    logic [IDW-1:0]   rq_id [3];
    logic [31:0]      rq_pc [3];
    logic [63:0]      rq_sb [3];

    logic             rb_valid;
    logic [IDW-1:0]   rb_thread_id;
    logic [31:0]      rb_pc;
    logic [63:0]      rb_scoreboard;
    logic [N-1:0]     rb_flush_mask;
    logic [2*N-1:0]   dbg_thread_state;

    rollback_sequencer #(.THREAD_NUMB(N), .FLUSH_CYCLES(FC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .wb_rollback_valid      (rq_v[0]),
        .wb_rollback_thread_id  (rq_id[0]),
        .wb_rollback_pc         (rq_pc[0]),
        .wb_scoreboard          (rq_sb[0]),
        .bc_rollback_enable     (rq_v[1]),
        .bc_rollback_thread_id  (rq_id[1]),
        .bc_rollback_pc         (rq_pc[1]),
        .bc_scoreboard          (rq_sb[1]),
        .dec_rollback_valid     (rq_v[2]),
        .dec_rollback_thread_id (rq_id[2]),
        .dec_rollback_pc        (rq_pc[2]),
        .dec_scoreboard         (rq_sb[2]),
        .rb_valid               (rb_valid),
        .rb_thread_id           (rb_thread_id),
        .rb_pc                  (rb_pc),
        .rb_scoreboard          (rb_scoreboard),
        .rb_flush_mask          (rb_flush_mask),
        .dbg_thread_state       (dbg_thread_state)
    );

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;

    // Reference model: per-thread mode, stored entry and flush cycles left.
    int             m_mode [N];
    int             m_src  [N];
    logic [31:0]    m_pc   [N];
    logic [63:0]    m_sb   [N];
    int             m_left [N];
    int             m_ptr;
    logic           m_valid;
    logic [IDW-1:0] m_id;
    logic [31:0]    m_rpc;
    logic [63:0]    m_rsb;
    logic [W-1:0]   exp_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < N; t++) begin
            m_mode[t] = M_IDLE;
            m_src[t]  = 0;
            m_pc[t]   = '0;
            m_sb[t]   = '0;
            m_left[t] = 0;
        end
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = '0;
        m_rpc   = '0;
        m_rsb   = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int g;
        int best;
        int t;
        g = -1;
        for (int k = 0; k < N; k++) begin
            t = (m_ptr + k) % N;
            if (g < 0 && m_mode[t] == M_PEND) g = t;
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_id    = IDW'(g);
            m_rpc   = m_pc[g];
            m_rsb   = m_sb[g];
            m_ptr   = (g + 1) % N;
            exp_q.push_back({m_id, m_rpc, m_rsb});
        end else begin
            m_valid = 1'b0;
        end
        for (int th = 0; th < N; th++) begin
            best = -1;
            for (int s = 0; s < 3; s++)
                if (best < 0 && rq_v[s] && rq_id[s] == IDW'(th)) best = s;
            if (m_mode[th] == M_FLUSH) begin
                m_left[th] = m_left[th] - 1;
                if (m_left[th] == 0) m_mode[th] = M_IDLE;
            end else if (best >= 0 && (m_mode[th] == M_IDLE || best < m_src[th])) begin
                m_mode[th] = M_PEND;
                m_src[th]  = best;
                m_pc[th]   = rq_pc[best];
                m_sb[th]   = rq_sb[best];
            end else if (th == g) begin
                m_mode[th] = M_FLUSH;
                m_left[th] = FC;
            end
        end
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        m = '0;
        for (int t = 0; t < N; t++) m[t] = (m_mode[t] == M_FLUSH);
        return m;
    endfunction

    task automatic compare_outputs();
        check("rb_valid", 128'(rb_valid), 128'(m_valid));
        check("rb_thread_id", 128'(rb_thread_id), 128'(m_id));
        check("rb_pc", 128'(rb_pc), 128'(m_rpc));
        check("rb_scoreboard", 128'(rb_scoreboard), 128'(m_rsb));
        check("rb_flush_mask", 128'(rb_flush_mask), 128'(model_mask()));
        if (rb_valid) begin
            nvalid++;
            if (exp_q.size() == 0) check("rb_unexpected", 128'(rb_valid), 128'(0));
            else check("rb_payload", 128'({rb_thread_id, rb_pc, rb_scoreboard}), 128'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        compare_outputs();
    endtask

    task automatic clear_reqs();
        for (int s = 0; s < 3; s++) begin
            rq_v[s]  = 1'b0;
            rq_id[s] = '0;
            rq_pc[s] = '0;
            rq_sb[s] = '0;
        end
    endtask

    task automatic set_req(input int s, input int id, input logic [31:0] pc);
        rq_v[s]  = 1'b1;
        rq_id[s] = IDW'(id);
        rq_pc[s] = pc;
        rq_sb[s] = {$urandom, $urandom};
    endtask

    task automatic reset_mid_cycle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_mask", 128'(rb_flush_mask), 128'(0));
        check("reset_valid", 128'(rb_valid), 128'(0));
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_reqs();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        check("reset_id", 128'(rb_thread_id), 128'(0));
        check("reset_pc", 128'(rb_pc), 128'(0));
        reset = 1'b0;

        // Single request, accepted on the first edge after reset release.
        set_req(1, 2, 32'h400);
        tick();
        clear_reqs();
        tick();
        check("single_valid", 128'(rb_valid), 128'(1));
        check("single_id", 128'(rb_thread_id), 128'(2));
        check("single_pc", 128'(rb_pc), 128'(32'h400));
        check("single_mask_c2", 128'(rb_flush_mask), 128'(8'h04));
        tick();
        check("single_mask_c3", 128'(rb_flush_mask), 128'(8'h04));
        tick();
        check("single_mask_c4", 128'(rb_flush_mask), 128'(8'h04));
        tick();
        check("single_mask_c5", 128'(rb_flush_mask), 128'(8'h00));

        // Same-cycle priority: wb wins.
        nvalid = 0;
        set_req(0, 1, 32'h100);
        set_req(1, 1, 32'h200);
        set_req(2, 1, 32'h300);
        tick();
        clear_reqs();
        tick();
        check("prio_pc", 128'(rb_pc), 128'(32'h100));
        repeat (5) tick();
        check("prio_count", 128'(nvalid), 128'(1));

        // dec then bc one cycle later: bc overwrites, old rollback still issued.
        nvalid = 0;
        set_req(2, 0, 32'hD00);
        tick();
        clear_reqs();
        set_req(1, 0, 32'hB00);
        tick();
        clear_reqs();
        check("ovr_first_pc", 128'(rb_pc), 128'(32'hD00));
        tick();
        check("ovr_second_valid", 128'(rb_valid), 128'(1));
        check("ovr_second_pc", 128'(rb_pc), 128'(32'hB00));
        repeat (6) tick();
        check("ovr_count", 128'(nvalid), 128'(2));

        // bc then dec one cycle later: dec dropped.
        nvalid = 0;
        set_req(1, 0, 32'hB10);
        tick();
        clear_reqs();
        set_req(2, 0, 32'hD10);
        tick();
        clear_reqs();
        check("drop_pc", 128'(rb_pc), 128'(32'hB10));
        repeat (6) tick();
        check("drop_count", 128'(nvalid), 128'(1));

        // Request during FLUSH is squashed.
        nvalid = 0;
        set_req(1, 3, 32'h300);
        tick();
        clear_reqs();
        tick();
        set_req(1, 3, 32'h330);
        tick();
        clear_reqs();
        repeat (6) tick();
        check("squash_count", 128'(nvalid), 128'(1));

        // Move the pointer to 6, then check wrap order 7, 0, 5.
        set_req(1, 5, 32'h500);
        tick();
        clear_reqs();
        repeat (6) tick();
        set_req(0, 7, 32'h700);
        set_req(1, 0, 32'h010);
        set_req(2, 5, 32'h550);
        tick();
        clear_reqs();
        tick();
        check("rr_c2", 128'(rb_thread_id), 128'(7));
        tick();
        check("rr_c3", 128'(rb_thread_id), 128'(0));
        tick();
        check("rr_c4", 128'(rb_thread_id), 128'(5));
        repeat (6) tick();

        // Reset while thread 4 is pending: nothing issues afterwards.
        set_req(1, 4, 32'h440);
        tick();
        clear_reqs();
        reset_mid_cycle();
        nvalid = 0;
        repeat (6) tick();
        check("reset_pending_count", 128'(nvalid), 128'(0));

        // Reset during FLUSH clears the mask immediately.
        set_req(1, 6, 32'h660);
        tick();
        clear_reqs();
        tick();
        tick();
        check("flush_before_reset", 128'(rb_flush_mask), 128'(8'h40));
        reset_mid_cycle();

        // Random traffic, biased to low thread IDs for contention.
        for (int c = 0; c < 800; c++) begin
            for (int s = 0; s < 3; s++) begin
                rq_v[s]  = ($urandom_range(0, 99) < 35);
                rq_id[s] = $urandom_range(0, 1) ? IDW'($urandom_range(0, 3)) : IDW'($urandom_range(0, N - 1));
                rq_pc[s] = $urandom;
                rq_sb[s] = {$urandom, $urandom};
            end
            tick();
        end
        clear_reqs();
        repeat (20) tick();
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
